// File: rtl/act_skew_feeder_pkg.sv
// Shared constants, state encoding and drain-length helper for the activation skew feeder.
package act_feed_pkg;

  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int HOP_LAT = 2;
  localparam int LEN_W   = 8;
  localparam int DATA_W  = 8;
  localparam int PSUM_W  = 16;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE_S} feed_state_e;

  // Cycles needed after the last accept for that beat to leave the longest lane.
  function automatic int drain_cycles(input int rows, input int cols, input int hop);
    int widest;
    widest = (rows > cols) ? rows : cols;
    return hop * (widest - 1) + 1;
  endfunction

  localparam int DRAIN_CNT = drain_cycles(ROWS, COLS, HOP_LAT);
  localparam int DRAIN_W   = $clog2(DRAIN_CNT + 1);

endpackage

// File: rtl/act_skew_feeder_if.sv
// Tile-control, input-stream and grid-edge signals of the activation skew feeder.
interface act_skew_feeder_if;
  import act_feed_pkg::*;

  logic                     START;
  logic [LEN_W-1:0]         LEN;
  logic                     IN_VALID;
  logic                     IN_READY;
  logic [ROWS*DATA_W-1:0]   IN_DATA;
  logic [ROWS*DATA_W-1:0]   A_OUT;
  logic [ROWS-1:0]          EN_LEFT;
  logic [COLS-1:0]          EN_TOP;
  logic [COLS*PSUM_W-1:0]   PSUM_TOP;
  logic                     BUSY;
  logic                     DONE;

  modport master (
    output START, LEN, IN_VALID, IN_DATA,
    input  IN_READY, A_OUT, EN_LEFT, EN_TOP, PSUM_TOP, BUSY, DONE
  );

  modport slave (
    input  START, LEN, IN_VALID, IN_DATA,
    output IN_READY, A_OUT, EN_LEFT, EN_TOP, PSUM_TOP, BUSY, DONE
  );

endinterface

// File: rtl/act_skew_feeder_skew_delay.sv
// Fixed-depth shift register with synchronous clear; depth 0 degenerates to a wire.
module skew_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk | rst;
    assign q = d;
  end else begin : g_shift
    logic [W-1:0] pipe_q [DEPTH];
    logic [W-1:0] pipe_d [DEPTH];

    always_comb begin
      pipe_d[0] = d;
      for (int k = 1; k < DEPTH; k++) pipe_d[k] = pipe_q[k-1];
    end

    // NOTE: every stage is cleared, not just the head, so a reset mid-tile
    // cannot leak stale beats onto the grid edge afterwards.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < DEPTH; k++) pipe_q[k] <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign q = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/act_skew_feeder.sv
// Tile FSM plus per-row/per-column skew lines feeding the weight-stationary PE grid edges.
module act_skew_feeder
  import act_feed_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  act_skew_feeder_if.slave  bus
);

  feed_state_e             state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        acc_cnt_q, acc_cnt_d;
  logic [DRAIN_W-1:0]      drain_cnt_q, drain_cnt_d;
  logic [ROWS*DATA_W-1:0]  s0_data_q, s0_data_d;
  logic                    s0_en_q, s0_en_d;
  logic                    accept;

  // NOTE: every variable gets its default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_cnt_d   = acc_cnt_q;
    drain_cnt_d = drain_cnt_q;
    accept      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.START && (bus.LEN != '0)) begin
          state_d   = STREAM;
          len_d     = bus.LEN;
          acc_cnt_d = '0;
        end
      end
      STREAM: begin
        if (bus.IN_VALID) begin
          accept    = 1'b1;
          acc_cnt_d = acc_cnt_q + LEN_W'(1);
          if (acc_cnt_d == len_q) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_W'(DRAIN_CNT - 1)) state_d = DONE_S;
        else drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
      end
      DONE_S:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Bubbles enter the lanes as zero-data, enable-0 beats.
    s0_data_d = accept ? bus.IN_DATA : '0;
    s0_en_d   = accept;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      len_q       <= '0;
      acc_cnt_q   <= '0;
      drain_cnt_q <= '0;
      s0_data_q   <= '0;
      s0_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_cnt_q   <= acc_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      s0_data_q   <= s0_data_d;
      s0_en_q     <= s0_en_d;
    end
  end

  logic [ROWS-1:0][DATA_W:0] row_lane;
  logic [COLS-1:0]           col_lane;

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    skew_delay #(.DEPTH(HOP_LAT * i), .W(DATA_W + 1)) u_row_dly (
      .clk (CLK),
      .rst (RST),
      .d   ({s0_en_q, s0_data_q[i*DATA_W +: DATA_W]}),
      .q   (row_lane[i])
    );
  end

  // Column lanes share the row-0 base register, so EN_TOP[0] lines up with EN_LEFT[0].
  for (genvar j = 0; j < COLS; j++) begin : g_col
    skew_delay #(.DEPTH(HOP_LAT * j), .W(1)) u_col_dly (
      .clk (CLK),
      .rst (RST),
      .d   (s0_en_q),
      .q   (col_lane[j])
    );
  end

  logic [ROWS*DATA_W-1:0] a_out;
  logic [ROWS-1:0]        en_left;

  always_comb begin
    a_out   = '0;
    en_left = '0;
    for (int i = 0; i < ROWS; i++) begin
      a_out[i*DATA_W +: DATA_W] = row_lane[i][DATA_W-1:0];
      en_left[i]                = row_lane[i][DATA_W];
    end
  end

  assign bus.A_OUT    = a_out;
  assign bus.EN_LEFT  = en_left;
  assign bus.EN_TOP   = col_lane;
  assign bus.PSUM_TOP = '0;
  assign bus.IN_READY = (state_q == STREAM);
  assign bus.BUSY     = (state_q == STREAM) || (state_q == DRAIN);
  assign bus.DONE     = (state_q == DONE_S);

endmodule
